// File: rtl/click_press_gen_pkg.sv
// Shared definitions for the click-to-keypress generator: FSM states and
// default timing/queue parameters.
package click_press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DEF_HOLD_CYCLES = 20;
  localparam int DEF_GAP_CYCLES  = 10;
  localparam int DEF_PEND_MAX    = 3;

  // Larger of two ints, used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/click_press_gen_pend_cnt.sv
// Saturating queue-depth counter for click requests. A simultaneous
// increment and decrement cancel out, so a full queue never reports a drop
// in that case.
module click_pend_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic [2:0] limit_i,
  output logic [2:0] count_o,
  output logic       ovf_o
);

  logic [2:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  // Next count: enqueue up to the limit, drop (and flag) beyond it.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    if (inc_i && !dec_i) begin
      if (count_q < limit_i) count_d = count_q + 3'd1;
      else                   ovf_d   = 1'b1;
    end else if (dec_i && !inc_i && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  // Count and overflow-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/click_press_gen.sv
// Turns single-cycle click requests into fixed-length key presses separated
// by a fixed low gap, queueing clicks that arrive while a press is running.
module click_press_gen
  import click_press_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int PEND_MAX    = DEF_PEND_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       click_i,
  output logic       key_o,
  output logic       busy_o,
  output logic [2:0] pending_o,
  output logic       overflow_o
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [2:0]    PEND_LIM = 3'(PEND_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;
  logic          busy_q, busy_d;

  logic          last_gap, pend_zero, pend_inc, pend_dec;
  logic [2:0]    pend_cnt;
  logic          pend_ovf;

  // Queue control: clicks while busy are enqueued, except on the last gap
  // cycle with an empty queue where the click launches the next press itself.
  always_comb begin
    last_gap  = (state_q == GAP) && (cnt_q == '0);
    pend_zero = (pend_cnt == 3'd0);
    pend_dec  = last_gap && !pend_zero;
    pend_inc  = click_i && (state_q != IDLE) && !(last_gap && pend_zero);
  end

  // Next state and timer; the single down-counter is reloaded on every
  // state entry and only decremented while non-zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (click_i) begin
          state_d = PRESS;
          cnt_d   = HOLD_LD;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (!pend_zero || click_i) begin
            state_d = PRESS;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    key_d  = (state_d == PRESS);
    busy_d = (state_d != IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
    end
  end

  click_pend_cnt u_pend (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (pend_inc),
    .dec_i   (pend_dec),
    .limit_i (PEND_LIM),
    .count_o (pend_cnt),
    .ovf_o   (pend_ovf)
  );

  assign key_o      = key_q;
  assign busy_o     = busy_q;
  assign pending_o  = pend_cnt;
  assign overflow_o = pend_ovf;

endmodule
